sar_opamp_phase_ctrl: RTL and testbench
=======================================

// Module: sar_opamp_phase_ctrl
// PURPOSE
//  Sequences the differential residue opamp and its switched-cap network in the SAR ADC front end.
//  Powers the opamp bias up and down, waits for bias warm-up, then runs one conversion cycle per start pulse.
//  A conversion is: sample (bottom-plate), non-overlap gap, amplify/hold.
//  Sits between the SAR conversion FSM (start/done) and the analog switch drivers (phase outputs).
// PARAMETERS
//  CNT_W       8   width of the internal phase down-counter
//  WARMUP_CYC  64  cycles opa_en must be high before the first conversion
//  SAMPLE_CYC  8   cycles phi_smp is high
//  NOV_CYC     1   non-overlap gap cycles between any two phases
//  AMP_CYC     16  cycles phi_amp is high (opamp settling)
//  AZ_CYC      8   cycles phi_az is high (only with OPAMP_AUTOZERO_EN)
//  Every *_CYC parameter is in the range 1..2**CNT_W. A static assertion checks this.
// PORTS
//  clk        in   1  clock
//  rst_n      in   1  asynchronous active-low reset
//  pd_req     in   1  level; 1 = opamp powered down
//  start      in   1  1-cycle request for a conversion; honoured only when ready=1
//  ready      out  1  warm, idle and able to accept start
//  busy       out  1  a conversion is in progress
//  done       out  1  1-cycle pulse when the amplify phase ends and the residue is held
//  opa_en     out  1  opamp bias enable
//  phi_smp    out  1  sampling switch (top plate)
//  phi_smp_e  out  1  early bottom-plate switch; falls 1 cycle before phi_smp
//  phi_amp    out  1  amplify/feedback switch
//  phi_az     out  1  autozero switch; tied 0 when the feature is disabled
// BEHAVIOUR
//  - All outputs are registered and glitch-free.
//  - Reset values: every output is 0. The FSM state is OFF and the counter is 0.
//  - States: OFF, WARMUP, IDLE, AZ, NOV_A, SAMPLE, NOV_S, AMP, DONE.
//  - OFF: all phases 0, opa_en=0.
//    pd_req=0 moves the FSM to WARMUP, with opa_en=1 from the next cycle on.
//  - WARMUP: runs for WARMUP_CYC cycles, then enters IDLE. ready=1 from the first IDLE cycle.
//  - IDLE: start=1 sets busy=1 the next cycle and enters SAMPLE (AZ when the feature is enabled).
//  - SAMPLE: phi_smp=1 for SAMPLE_CYC cycles. phi_smp_e=1 in the same cycles except the last.
//    If SAMPLE_CYC=1, phi_smp_e is never asserted.
//  - NOV_S: all phases 0 for NOV_CYC cycles.
//  - AMP: phi_amp=1 for AMP_CYC cycles.
//  - DONE: a single cycle with done=1, busy=0 and phi_amp=0, then IDLE.
//    Back-to-back operation: start in the DONE cycle is accepted (ready=1 in DONE).
//  - Latency (feature off): start to done = SAMPLE_CYC+NOV_CYC+AMP_CYC+1 cycles.
//  - Invariants: phi_smp and phi_amp are never both 1. phi_az and phi_amp are never both 1.
//    No phase is 1 while opa_en=0.
//  - Counter: loaded with N-1 on state entry; the state ends when the counter is 0.
//  - start while busy, in WARMUP or in OFF: ignored, not queued.
//  - pd_req=1 in any state: the next state is OFF. All phases are 0 and opa_en=0 from the next cycle.
//    The aborted conversion never asserts done. Re-entry from OFF always passes through a full WARMUP.
//  - pd_req and start in the same cycle: pd_req wins.
//  - Asynchronous reset mid-conversion: outputs go to their reset values immediately, with no done pulse.
// CONFIGURATION
//  OPAMP_AUTOZERO_EN defined:
//   - The conversion starts with AZ: phi_az=1 for AZ_CYC cycles. Opamp offset is stored on the caps.
//   - NOV_A (NOV_CYC cycles, all phases 0) follows, then SAMPLE.
//   - Latency grows by AZ_CYC+NOV_CYC.
//  OPAMP_AUTOZERO_EN undefined:
//   - AZ and NOV_A are unreachable, phi_az is constant 0, and AZ_CYC is unused.
// STRUCTURE
//  Package sar_opa_pkg holds:
//   - the state enum opa_state_t;
//   - the struct opa_phase_t {opa_en, phi_smp, phi_smp_e, phi_amp, phi_az};
//   - the constant PHASE_ALL_OFF.
//  Sub-module sar_phase_timer (CNT_W): load, value, tick and expired outputs.
//   It is a down-counter, reset to 0, and is reused by other SAR sequencers.
//  The top level holds only the FSM and the output registers.
// TESTING
//  1. Reset then pd_req=0: opa_en=1 one cycle later. ready rises exactly 64 cycles later. All phases 0 throughout.
//  2. Defaults, feature off: start in IDLE.
//     - phi_smp high 8 cycles, phi_smp_e high for the first 7 of them.
//     - A 1-cycle gap, then phi_amp high 16 cycles.
//     - done arrives 26 cycles after start.
//  3. Extra start pulses while busy=1: no effect. Exactly one done. Start in the DONE cycle triggers an immediate second conversion.
//  4. pd_req=1 in cycle 5 of AMP: all outputs 0 the next cycle and no done.
//     - Then pd_req=0: the full 64-cycle WARMUP repeats before ready.
//  5. OPAMP_AUTOZERO_EN defined: phi_az high 8 cycles, a 1-cycle gap, then SAMPLE. done 35 cycles after start.
//  6. Random start/pd_req stress with assertions:
//     - phase exclusivity;
//     - no phase while opa_en=0;
//     - the done/busy relation;
//     - an async rst_n pulse mid-SAMPLE clears everything.

Source files
------------

// File: rtl/sar_opa_pkg.sv
// Shared types for the SAR residue-opamp phase sequencer: FSM states, phase bundle
// and the helper that maps a state to its static switch pattern.
package sar_opa_pkg;

    typedef enum logic [3:0] {
        ST_OFF,
        ST_WARMUP,
        ST_IDLE,
        ST_AZ,
        ST_NOV_A,
        ST_SAMPLE,
        ST_NOV_S,
        ST_AMP,
        ST_DONE
    } opa_state_t;

    typedef struct packed {
        logic opa_en;
        logic phi_smp;
        logic phi_smp_e;
        logic phi_amp;
        logic phi_az;
    } opa_phase_t;

    localparam opa_phase_t PHASE_ALL_OFF = '0;

    // phi_smp_e is not derivable from the state alone; the caller fills it in.
    function automatic opa_phase_t phase_of(input opa_state_t s);
        opa_phase_t p;
        p         = PHASE_ALL_OFF;
        p.opa_en  = (s != ST_OFF);
        p.phi_smp = (s == ST_SAMPLE);
        p.phi_amp = (s == ST_AMP);
        p.phi_az  = (s == ST_AZ);
        return p;
    endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// Loadable down-counter used to time sequencer phases; saturates at zero and
// flags expiry when it reads zero.
module sar_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign value   = r_cnt;
    assign expired = (r_cnt == '0);

endmodule

// File: rtl/sar_opamp_phase_ctrl.sv
// Residue-opamp power/phase sequencer: warm-up, then sample / gap / amplify per start.
// Optional autozero phase ahead of sampling is enabled by defining OPAMP_AUTOZERO_EN.
module sar_opamp_phase_ctrl
    import sar_opa_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int WARMUP_CYC = 64,
    parameter int SAMPLE_CYC = 8,
    parameter int NOV_CYC    = 1,
    parameter int AMP_CYC    = 16,
    parameter int AZ_CYC     = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pd_req,
    input  logic start,
    output logic ready,
    output logic busy,
    output logic done,
    output logic opa_en,
    output logic phi_smp,
    output logic phi_smp_e,
    output logic phi_amp,
    output logic phi_az
);

    if ((WARMUP_CYC < 1) || (WARMUP_CYC > 2**CNT_W) ||
        (SAMPLE_CYC < 1) || (SAMPLE_CYC > 2**CNT_W) ||
        (NOV_CYC    < 1) || (NOV_CYC    > 2**CNT_W) ||
        (AMP_CYC    < 1) || (AMP_CYC    > 2**CNT_W) ||
        (AZ_CYC     < 1) || (AZ_CYC     > 2**CNT_W)) begin : g_cyc_range_err
        $error("sar_opamp_phase_ctrl: every *_CYC must be within 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LD_WARM = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SMP  = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_NOV  = CNT_W'(NOV_CYC - 1);
    localparam logic [CNT_W-1:0] LD_AMP  = CNT_W'(AMP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_AZ   = CNT_W'(AZ_CYC - 1);

`ifdef OPAMP_AUTOZERO_EN
    localparam opa_state_t ST_CONV_FIRST = ST_AZ;
`else
    localparam opa_state_t ST_CONV_FIRST = ST_SAMPLE;
`endif

    opa_state_t       r_state;
    opa_state_t       w_nxt_state;
    opa_phase_t       r_phase;
    opa_phase_t       w_phase_nxt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_load;
    logic             w_tick;
    logic             w_expired;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;

    sar_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (w_tick),
        .value    (w_cnt),
        .expired  (w_expired)
    );

    // Power-down dominates every state, including a pending start.
    always_comb begin
        w_nxt_state = r_state;
        if (pd_req) begin
            w_nxt_state = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:             w_nxt_state = ST_WARMUP;
                ST_WARMUP:          if (w_expired) w_nxt_state = ST_IDLE;
                ST_IDLE, ST_DONE:   w_nxt_state = start ? ST_CONV_FIRST : ST_IDLE;
                ST_AZ:              if (w_expired) w_nxt_state = ST_NOV_A;
                ST_NOV_A:           if (w_expired) w_nxt_state = ST_SAMPLE;
                ST_SAMPLE:          if (w_expired) w_nxt_state = ST_NOV_S;
                ST_NOV_S:           if (w_expired) w_nxt_state = ST_AMP;
                ST_AMP:             if (w_expired) w_nxt_state = ST_DONE;
                default:            w_nxt_state = ST_OFF;
            endcase
        end
    end

    // Every state change is an entry into a new phase, so it reloads the timer.
    always_comb begin
        w_load = (w_nxt_state != r_state);
        w_tick = ~w_load;
        case (w_nxt_state)
            ST_WARMUP:          w_load_val = LD_WARM;
            ST_AZ:              w_load_val = LD_AZ;
            ST_NOV_A, ST_NOV_S: w_load_val = LD_NOV;
            ST_SAMPLE:          w_load_val = LD_SMP;
            ST_AMP:             w_load_val = LD_AMP;
            default:            w_load_val = '0;
        endcase
    end

    // The early bottom-plate switch drops one cycle before the sample phase ends,
    // i.e. it is high whenever the upcoming counter value is non-zero.
    always_comb begin
        w_phase_nxt           = phase_of(w_nxt_state);
        w_phase_nxt.phi_smp_e = (w_nxt_state == ST_SAMPLE) &&
                                (w_load ? (w_load_val != '0) : (w_cnt > CNT_W'(1)));
`ifndef OPAMP_AUTOZERO_EN
        w_phase_nxt.phi_az    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_phase <= PHASE_ALL_OFF;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_phase_nxt;
            r_ready <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_DONE);
            r_busy  <= (w_nxt_state == ST_AZ)     || (w_nxt_state == ST_NOV_A) ||
                       (w_nxt_state == ST_SAMPLE) || (w_nxt_state == ST_NOV_S) ||
                       (w_nxt_state == ST_AMP);
            r_done  <= (w_nxt_state == ST_DONE);
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign opa_en    = r_phase.opa_en;
    assign phi_smp   = r_phase.phi_smp;
    assign phi_smp_e = r_phase.phi_smp_e;
    assign phi_amp   = r_phase.phi_amp;
    assign phi_az    = r_phase.phi_az;

endmodule

// File: tb/tb_sar_opamp_phase_ctrl.sv
// Bench for sar_opamp_phase_ctrl: timeline model of power/warm-up/conversion position,
// directed latency and abort checks, then random start/pd_req stress and an async reset.
module tb_sar_opamp_phase_ctrl;

    localparam int W   = 64;
    localparam int S   = 8;
    localparam int N   = 1;
    localparam int AMP = 16;
    localparam int AZ  = 8;
`ifdef OPAMP_AUTOZERO_EN
    localparam int A       = AZ + N;
    localparam int LAT_LIT = 35;
`else
    localparam int A       = 0;
    localparam int LAT_LIT = 26;
`endif
    localparam int L = A + S + N + AMP + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pd_req = 1'b1;
    logic start = 1'b0;
    logic ready, busy, done, opa_en, phi_smp, phi_smp_e, phi_amp, phi_az;

    sar_opamp_phase_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pd_req    (pd_req),
        .start     (start),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .opa_en    (opa_en),
        .phi_smp   (phi_smp),
        .phi_smp_e (phi_smp_e),
        .phi_amp   (phi_amp),
        .phi_az    (phi_az)
    );

    always #5 clk = ~clk;

    // Model: powered flag, remaining warm-up cycles, and position inside a conversion.
    bit m_on;
    int m_warm;
    int m_pos;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || pd_req) begin
            m_on   = 1'b0;
            m_warm = 0;
            m_pos  = -1;
        end else if (!m_on) begin
            m_on   = 1'b1;
            m_warm = W;
        end else if (m_warm > 0) begin
            m_warm = m_warm - 1;
        end else if (m_pos >= 0 && m_pos < L - 1) begin
            m_pos = m_pos + 1;
        end else begin
            m_pos = start ? 0 : -1;
        end
    end

    function automatic logic [7:0] model_out();
        logic rdy, bsy, dn, en, smp, smpe, amp, az;
        {rdy, bsy, dn, en, smp, smpe, amp, az} = 8'h00;
        if (m_on) begin
            en = 1'b1;
            if (m_warm == 0) begin
                rdy  = (m_pos < 0) || (m_pos == L - 1);
                bsy  = (m_pos >= 0) && (m_pos < L - 1);
                dn   = (m_pos == L - 1);
                az   = (m_pos >= 0) && (m_pos < A - N);
                smp  = (m_pos >= A) && (m_pos < A + S);
                smpe = (m_pos >= A) && (m_pos < A + S - 1);
                amp  = (m_pos >= A + S + N) && (m_pos < A + S + N + AMP);
            end
        end
        return {rdy, bsy, dn, en, smp, smpe, amp, az};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {ready, busy, done, opa_en, phi_smp, phi_smp_e, phi_amp, phi_az};
    endfunction

    int checks = 0;
    int errors = 0;
    int n = 0;
    int t_rel = 0, t_en = 0, t_rdy = 0, t_start = 0, lat = 0, done_cnt = 0;
    int c_smp = 0, c_smpe = 0, c_amp = 0, c_az = 0;
    int r_smp = 0, r_smpe = 0, r_amp = 0, r_az = 0;
    logic p_pd = 1'b1, p_en = 1'b0, p_rdy = 1'b0;
    logic p_smp = 1'b0, p_smpe = 1'b0, p_amp = 1'b0, p_az = 1'b0;

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Runs at each falling edge; the inputs visible here are those of the previous cycle.
    task automatic do_sample();
        logic [7:0] act, want;
        n++;
        act  = dut_vec();
        want = model_out();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL model cycle %0d got %b want %b (rdy bsy dn en smp smpe amp az)", n, act, want);
        end
        checks++;
        if ((phi_smp && phi_amp) || (phi_az && phi_amp) ||
            (!opa_en && (phi_smp || phi_smp_e || phi_amp || phi_az)) ||
            (done && (busy || !ready))) begin
            errors++;
            $display("FAIL invariant cycle %0d got %b", n, act);
        end
        if (!pd_req && p_pd) t_rel = n - 1;
        if (opa_en && !p_en) t_en = n;
        if (ready && !p_rdy) t_rdy = n;
        if (done) begin
            done_cnt++;
            lat = n - t_start;
        end
        if (start && p_rdy && !pd_req && rst_n) t_start = n - 1;
        if (phi_smp) c_smp++;     else if (p_smp)  begin r_smp  = c_smp;  c_smp  = 0; end
        if (phi_smp_e) c_smpe++;  else if (p_smpe) begin r_smpe = c_smpe; c_smpe = 0; end
        if (phi_amp) c_amp++;     else if (p_amp)  begin r_amp  = c_amp;  c_amp  = 0; end
        if (phi_az) c_az++;       else if (p_az)   begin r_az   = c_az;   c_az   = 0; end
        p_pd = pd_req; p_en = opa_en; p_rdy = ready;
        p_smp = phi_smp; p_smpe = phi_smp_e; p_amp = phi_amp; p_az = phi_az;
    endtask

    task automatic step(input logic pd, input logic st);
        @(negedge clk);
        do_sample();
        #1;
        pd_req = pd;
        start  = st;
    endtask

    task automatic wait_ready(input int max);
        for (int i = 0; i < max && !ready; i++) step(1'b0, 1'b0);
        check_eq("ready_timeout", int'(ready), 1);
    endtask

    task automatic wait_done(input int target, input int max);
        for (int i = 0; i < max && done_cnt < target; i++) step(1'b0, 1'b0);
        check_eq("done_timeout", done_cnt, target);
    endtask

    initial begin
        int d0;
        repeat (3) step(1'b1, 1'b0);
        check_eq("reset_outs", int'(dut_vec()), 0);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0);
        check_eq("off_outs", int'(dut_vec()), 0);

        // Power-up: opa_en one cycle after release, ready 64 cycles after that
        step(1'b0, 1'b0);
        wait_ready(200);
        check_eq("opa_en_delay", t_en - t_rel, 1);
        check_eq("warmup_len", t_rdy - t_en, 64);

        // Single conversion
        d0 = done_cnt;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        wait_done(d0 + 1, 100);
        check_eq("latency", lat, LAT_LIT);
        check_eq("smp_len", r_smp, 8);
        check_eq("smpe_len", r_smpe, 7);
        check_eq("amp_len", r_amp, 16);
`ifdef OPAMP_AUTOZERO_EN
        check_eq("az_len", r_az, 8);
`endif

        // Starts while busy are dropped; a start in the DONE cycle chains a second run
        wait_ready(10);
        d0 = done_cnt;
        step(1'b0, 1'b1);
        for (int k = 1; k < L; k++) step(1'b0, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        wait_done(d0 + 2, 100);
        check_eq("b2b_latency", lat, LAT_LIT);
        repeat (L + 5) step(1'b0, 1'b0);
        check_eq("b2b_done_count", done_cnt - d0, 2);

        // Power-down in the fifth AMP cycle aborts without done
        wait_ready(10);
        d0 = done_cnt;
        step(1'b0, 1'b1);
        repeat (A + S + N + 4) step(1'b0, 1'b0);
        check_eq("in_amp", int'(phi_amp), 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("abort_outs", int'(dut_vec()), 0);
        repeat (5) step(1'b1, 1'b0);
        check_eq("abort_no_done", done_cnt, d0);
        step(1'b0, 1'b0);
        wait_ready(200);
        check_eq("rewarm_len", t_rdy - t_en, 64);

        // Random stress
        for (int i = 0; i < 4000; i++)
            step(1'($urandom_range(0, 999) < 4), 1'($urandom_range(0, 99) < 30));

        // Async reset in the middle of SAMPLE
        step(1'b0, 1'b0);
        wait_ready(300);
        step(1'b0, 1'b1);
        repeat (A + 3) step(1'b0, 1'b0);
        check_eq("in_sample", int'(phi_smp), 1);
        d0 = done_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_outs", int'(dut_vec()), 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (80) step(1'b0, 1'b0);
        check_eq("rst_no_done", done_cnt, d0);
        check_eq("rst_rewarm_len", t_rdy - t_en, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", n);
        $fatal(1, "watchdog");
    end

endmodule
